bcd_updown_counter_n: RTL and testbench
=======================================

// Module: bcd_updown_counter_n
// PURPOSE
//   Parametrised N-digit BCD up/down counter, the successor of the 2-digit scoreboard counter.
//   Adds async reset, synchronous parallel load, wrap/saturate mode, and carry/borrow pulses for cascading.
//   Feeds scoreboard display decoders; driven by the scoreboard controller's inc/dec/erase strobes.
// PARAMETERS
//   DIGITS    2   number of BCD decades (1..8); digit 0 is the least significant
//   SAT_DEF   0   mode after reset: 0 = wrap, 1 = saturate (overridden live by sat_i)
// PORTS
//   clk          in   1          single clock, rising edge
//   rst_n        in   1          asynchronous, active-low reset
//   inc_i        in   1          count up by one this cycle
//   dec_i        in   1          count down by one this cycle
//   erase_i      in   1          synchronous clear to all zeros
//   load_i       in   1          synchronous parallel load (BCDCNT_LOAD_EN only)
//   load_val_i   in   4*DIGITS   BCD value for load; nibble k = digit k
//   sat_i        in   1          1 = saturate at 0 / max, 0 = wrap
//   count_o      out  4*DIGITS   registered count; nibble k = digit k
//   carry_o      out  1          1-cycle pulse: inc_i applied at all-9s
//   borrow_o     out  1          1-cycle pulse: dec_i applied at all-0s
//   at_max_o     out  1          combinational: count_o is all 9s
//   at_zero_o    out  1          combinational: count_o is all 0s
//   load_err_o   out  1          1-cycle pulse: load rejected (any nibble > 9)
// BEHAVIOUR
//   Reset (rst_n=0, async): count_o=0, carry_o=0, borrow_o=0, load_err_o=0; at_zero_o=1.
//   All updates take effect at the next rising clk; count_o is the state register (latency 1).
//   Priority per cycle: erase_i > load_i > (inc_i & dec_i) > inc_i > dec_i.
//   erase_i: count -> 0; the pulses stay 0 that cycle.
//   load_i: every nibble <= 9 -> count <= load_val_i; otherwise count holds and load_err_o pulses.
//   inc_i & dec_i together: count holds, no pulses.
//   inc_i: digit k increments iff every digit j<k is 9; a digit at 9 that increments goes to 0.
//   dec_i: digit k decrements iff every digit j<k is 0; a digit at 0 that decrements goes to 9.
//   Overflow (inc at all-9s): wrap -> all 0s, carry_o=1; saturate -> hold all 9s, carry_o=1.
//   Underflow (dec at all-0s): wrap -> all 9s, borrow_o=1; saturate -> hold 0, borrow_o=1.
//   carry_o/borrow_o/load_err_o are registered, high exactly the cycle after the event, else 0.
//   Digits never hold a non-BCD value (A-F) in any reachable state.
//   rst_n asserted mid-count: immediate clear regardless of clk; the first edge after release counts normally.
//   No other FSM; the state is the DIGITS x 4-bit register plus the 3 pulse flops.
// CONFIGURATION
//   BCDCNT_LOAD_EN defined: load_i/load_val_i are honoured as above.
//   BCDCNT_LOAD_EN undefined: ports remain; load_i is ignored (priority drops to inc/dec);
//     load_err_o is tied 0; no load mux and no validity check are built.
// STRUCTURE
//   Package bcd_pkg: typedef logic [3:0] bcd_digit_t; localparam BCD_MAX = 4'd9;
//     function is_bcd(bcd_digit_t) shared with the display decoders.
//   Sub-module bcd_digit_cell: one decade; inputs up_en, dn_en; outputs next value
//     plus ripple terms is9/is0. A generate loop chains DIGITS cells and the top
//     holds the register, priority logic, mode and the pulse flops.
// TESTING
//   DIGITS=2, wrap: reset, 100 x inc_i -> count_o 00, carry_o high exactly 1 cycle at the 100th.
//   DIGITS=3: load 199 (LOAD_EN), inc -> 200; dec -> 199; load 1A0 -> count holds, load_err_o pulse.
//   DIGITS=2, sat_i=1: from 00 dec -> stays 00, borrow_o pulse; from 99 inc -> stays 99, carry_o pulse.
//   inc_i=dec_i=1 at 45 -> 45; erase_i with inc_i at 45 -> 00, no carry; erase_i with load_i -> 00.
//   rst_n low mid-stream between clk edges -> count_o 00 immediately; release, inc -> 01.
//   Without BCDCNT_LOAD_EN: load_i=1, load_val_i=57, inc_i=1 at 03 -> 04, load_err_o stays 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the scoreboard counter and display decoders.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: computes the next digit value for a step up or down and
// exposes the is9/is0 terms used to ripple enables to higher decades.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t cur,
  input  logic       up_en,
  input  logic       dn_en,
  output bcd_digit_t nxt,
  output logic       is9,
  output logic       is0
);

  assign is9 = (cur == BCD_MAX);
  assign is0 = (cur == 4'd0);

  // Step the decade, rolling 9->0 on up and 0->9 on down so no A-F value appears.
  always_comb begin
    nxt = cur;
    if (up_en) begin
      nxt = is9 ? 4'd0 : cur + 4'd1;
    end else if (dn_en) begin
      nxt = is0 ? BCD_MAX : cur - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with erase, optional parallel load, wrap or
// saturate mode and registered carry/borrow/load-error pulses.
// Build option: define BCDCNT_LOAD_EN to honour load_i/load_val_i; without it
// the load ports are present but ignored and load_err_o is tied low.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter bit SAT_DEF = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  erase_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  sat_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  carry_o,
  output logic                  borrow_o,
  output logic                  at_max_o,
  output logic                  at_zero_o,
  output logic                  load_err_o
);

  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_d;
  logic [4*DIGITS-1:0] count_step;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic                load_err_q, load_err_d;

  logic [DIGITS-1:0]   is9;
  logic [DIGITS-1:0]   is0;
  logic [DIGITS:0]     up_ok;
  logic [DIGITS:0]     dn_ok;
  logic                all9;
  logic                all0;
  logic                step_up;
  logic                step_dn;
  logic                sat_mode;

  // SAT_DEF only documents the intended power-up mode; sat_i selects the
  // mode live on every cycle, so the parameter feeds no logic.
  logic unused_sat_def;
  assign unused_sat_def = SAT_DEF;
  assign sat_mode       = sat_i;

  // A lone inc or dec steps the digits; both together cancel.
  assign step_up = inc_i & ~dec_i;
  assign step_dn = dec_i & ~inc_i;

  // Ripple enables: digit k moves when every lower digit is at its rollover value.
  always_comb begin
    up_ok[0] = 1'b1;
    dn_ok[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      up_ok[k+1] = up_ok[k] & is9[k];
      dn_ok[k+1] = dn_ok[k] & is0[k];
    end
  end

  assign all9 = up_ok[DIGITS];
  assign all0 = dn_ok[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .cur   (count_q[4*g +: 4]),
      .up_en (step_up & up_ok[g]),
      .dn_en (step_dn & dn_ok[g]),
      .nxt   (count_step[4*g +: 4]),
      .is9   (is9[g]),
      .is0   (is0[g])
    );
  end

`ifdef BCDCNT_LOAD_EN
  logic load_ok;

  // A load is accepted only when every nibble is a decimal digit.
  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!is_bcd(load_val_i[4*k +: 4])) begin
        load_ok = 1'b0;
      end
    end
  end
`else
  logic unused_load;
  assign unused_load = ^{load_i, load_val_i};
`endif

  // Next-state selection in priority order: erase, load, inc&dec, inc, dec.
  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (erase_i) begin
      count_d = '0;
`ifdef BCDCNT_LOAD_EN
    end else if (load_i) begin
      if (load_ok) begin
        count_d = load_val_i;
      end else begin
        load_err_d = 1'b1;
      end
`endif
    end else if (step_up) begin
      carry_d = all9;
      count_d = (all9 && sat_mode) ? count_q : count_step;
    end else if (step_dn) begin
      borrow_d = all0;
      count_d  = (all0 && sat_mode) ? count_q : count_step;
    end
  end

  // Count register and the three event pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_q;
  assign carry_o    = carry_q;
  assign borrow_o   = borrow_q;
  assign load_err_o = load_err_q;
  assign at_max_o   = all9;
  assign at_zero_o  = all0;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: a 2-digit and a 3-digit instance share the
// same strobes and are compared against an integer-valued reference model.
module tb_bcd_updown_counter_n;

`ifdef BCDCNT_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        inc;
  logic        dec;
  logic        erase;
  logic        load;
  logic        sat;
  logic [11:0] load_val;

  logic [7:0]  count2;
  logic        carry2, borrow2, at_max2, at_zero2, load_err2;
  logic [11:0] count3;
  logic        carry3, borrow3, at_max3, at_zero3, load_err3;

  int checks = 0;
  int errors = 0;

  int m2, m3;
  bit ec2, eb2, ee2, ec3, eb3, ee3;

  bcd_updown_counter_n #(.DIGITS(2), .SAT_DEF(1'b0)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (inc),
    .dec_i      (dec),
    .erase_i    (erase),
    .load_i     (load),
    .load_val_i (load_val[7:0]),
    .sat_i      (sat),
    .count_o    (count2),
    .carry_o    (carry2),
    .borrow_o   (borrow2),
    .at_max_o   (at_max2),
    .at_zero_o  (at_zero2),
    .load_err_o (load_err2)
  );

  bcd_updown_counter_n #(.DIGITS(3), .SAT_DEF(1'b0)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (inc),
    .dec_i      (dec),
    .erase_i    (erase),
    .load_i     (load),
    .load_val_i (load_val),
    .sat_i      (sat),
    .count_o    (count3),
    .carry_o    (carry3),
    .borrow_o   (borrow3),
    .at_max_o   (at_max3),
    .at_zero_o  (at_zero3),
    .load_err_o (load_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int n);
    logic [31:0] r = '0;
    int t = v;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: the counter as a plain integer in 0..10^n-1.
  task automatic ref_step(input int v, input int n, input bit er, input bit ld,
                          input logic [31:0] lv, input bit up, input bit dn, input bit st,
                          output int v_out, output bit c, output bit b, output bit le);
    int mx = pow10(n) - 1;
    int val = 0;
    bit bad = 1'b0;
    v_out = v;
    c = 1'b0;
    b = 1'b0;
    le = 1'b0;
    if (er) begin
      v_out = 0;
    end else if (LOAD_EN && ld) begin
      for (int k = 0; k < n; k++) begin
        int nib = int'(lv[4*k +: 4]);
        if (nib > 9) bad = 1'b1;
        val = val + nib * pow10(k);
      end
      if (bad) le = 1'b1;
      else v_out = val;
    end else if (up && dn) begin
      v_out = v;
    end else if (up) begin
      if (v == mx) begin
        c = 1'b1;
        v_out = st ? mx : 0;
      end else begin
        v_out = v + 1;
      end
    end else if (dn) begin
      if (v == 0) begin
        b = 1'b1;
        v_out = st ? 0 : mx;
      end else begin
        v_out = v - 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count2"},   32'(count2),    to_bcd(m2, 2));
    check({tag, ".carry2"},   32'(carry2),    32'(ec2));
    check({tag, ".borrow2"},  32'(borrow2),   32'(eb2));
    check({tag, ".lerr2"},    32'(load_err2), 32'(ee2));
    check({tag, ".atmax2"},   32'(at_max2),   32'(m2 == 99));
    check({tag, ".atzero2"},  32'(at_zero2),  32'(m2 == 0));
    check({tag, ".count3"},   32'(count3),    to_bcd(m3, 3));
    check({tag, ".carry3"},   32'(carry3),    32'(ec3));
    check({tag, ".borrow3"},  32'(borrow3),   32'(eb3));
    check({tag, ".lerr3"},    32'(load_err3), 32'(ee3));
    check({tag, ".atmax3"},   32'(at_max3),   32'(m3 == 999));
    check({tag, ".atzero3"},  32'(at_zero3),  32'(m3 == 0));
  endtask

  task automatic step(input bit er, input bit ld, input logic [11:0] lv,
                      input bit up, input bit dn, input string tag);
    int n2, n3;
    erase    = er;
    load     = ld;
    load_val = lv;
    inc      = up;
    dec      = dn;
    @(posedge clk);
    #1;
    ref_step(m2, 2, er, ld, 32'(lv), up, dn, sat, n2, ec2, eb2, ee2);
    ref_step(m3, 3, er, ld, 32'(lv), up, dn, sat, n3, ec3, eb3, ee3);
    m2 = n2;
    m3 = n3;
    erase = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
    dec   = 1'b0;
    compare_all(tag);
  endtask

  task automatic clear_model();
    m2 = 0; m3 = 0;
    ec2 = 0; eb2 = 0; ee2 = 0;
    ec3 = 0; eb3 = 0; ee3 = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    erase    = 1'b0;
    load     = 1'b0;
    sat      = 1'b0;
    load_val = '0;
    clear_model();

    #3;
    compare_all("reset");
    rst_n = 1'b1;

    // Wrap mode: 100 increments, the 2-digit instance rolls over on the last.
    for (int i = 0; i < 100; i++) step(0, 0, 12'h000, 1, 0, "inc100");

    // Load 199, step up and down, then reject a non-BCD load.
    step(1, 0, 12'h000, 0, 0, "erase1");
    step(0, 1, 12'h199, 0, 0, "load199");
    step(0, 0, 12'h000, 1, 0, "inc_after_load");
    step(0, 0, 12'h000, 0, 1, "dec_after_load");
    step(0, 1, 12'h1A0, 0, 0, "load_bad");
    step(0, 0, 12'h000, 0, 0, "idle_after_bad");

    // Saturate at zero, then reach all-9s via a wrap underflow and saturate at max.
    step(1, 0, 12'h000, 0, 0, "erase2");
    sat = 1'b1;
    step(0, 0, 12'h000, 0, 1, "sat_dec_zero");
    step(0, 0, 12'h000, 0, 0, "sat_idle");
    sat = 1'b0;
    step(0, 0, 12'h000, 0, 1, "wrap_dec_zero");
    sat = 1'b1;
    step(0, 0, 12'h000, 1, 0, "sat_inc_max");
    step(0, 0, 12'h000, 1, 0, "sat_inc_max2");
    sat = 1'b0;

    // Priority cases at 45.
    step(1, 0, 12'h000, 0, 0, "erase3");
    for (int i = 0; i < 45; i++) step(0, 0, 12'h000, 1, 0, "to45");
    step(0, 0, 12'h000, 1, 1, "inc_and_dec");
    step(1, 0, 12'h000, 1, 0, "erase_with_inc");
    for (int i = 0; i < 45; i++) step(0, 0, 12'h000, 1, 0, "to45b");
    step(1, 1, 12'h077, 0, 0, "erase_with_load");

    // Asynchronous reset between edges, then count from zero.
    for (int i = 0; i < 7; i++) step(0, 0, 12'h000, 1, 0, "pre_rst");
    rst_n = 1'b0;
    #1;
    clear_model();
    compare_all("async_rst");
    #1;
    rst_n = 1'b1;
    step(0, 0, 12'h000, 1, 0, "inc_after_rst");

    // Load and inc together at 03: load wins only when the load path is built.
    step(1, 0, 12'h000, 0, 0, "erase4");
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 1, 0, "to03");
    step(0, 1, 12'h057, 1, 0, "load_with_inc");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [11:0] lv;
      bit er, ld, up, dn;
      r  = int'($urandom_range(0, 99));
      er = (r < 4);
      ld = (r >= 4 && r < 14);
      up = ($urandom_range(0, 2) != 0);
      dn = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 7) == 0) lv[4*k +: 4] = 4'($urandom_range(10, 15));
        else lv[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 19) == 0) sat = ~sat;
      step(er, ld, lv, up, dn, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
